// File: rtl/ysyx_25040109_wbu.sv
// Write-back / commit stage.
// Holds one completed instruction, commits it to the register file when the
// IFU takes the next-PC redirect, counts retired instructions, and turns a bus
// error response into a sticky halt that only reset clears.
module ysyx_25040109_wbu #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_dnpc,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_wen,
  input  logic             in_is_load,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_load_data,
  input  logic             in_resp_err,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [XLEN-1:0]  commit_dnpc,
  output logic [XLEN-1:0]  commit_pc,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [4:0]       busy_rd,
  output logic             busy_valid,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halt,
  output logic [XLEN-1:0]  halt_pc
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_dnpc;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic [XLEN-1:0]   r_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic              r_halt;
  logic [XLEN-1:0]   r_halt_pc;

  logic              w_full;
  logic              w_commit_valid;
  logic              w_commit_fire;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_cap_wen;
  logic [XLEN-1:0]   w_cap_data;

  // Handshake and capture terms derived from the current state and held entry.
  always_comb begin
    w_full         = (r_state == S_FULL);
    w_commit_valid = w_full & ~r_err;
    w_commit_fire  = w_commit_valid & commit_ready;
    // A new result may only replace the held one in the cycle it commits.
    w_in_ready     = (r_state == S_EMPTY) | (w_full & w_commit_fire & ~r_err);
    w_in_fire      = in_valid & w_in_ready;
    // Writes to x0 are dropped at capture so rd=0 never raises a strobe.
    w_cap_wen      = in_rd_wen & (in_rd != 5'd0);
    w_cap_data     = in_is_load ? in_load_data : in_alu_result;
  end

  // Stage state machine: holds the entry, counts retirements, latches the halt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_EMPTY;
      r_pc         <= '0;
      r_dnpc       <= '0;
      r_rd         <= 5'd0;
      r_wen        <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_retire_cnt <= '0;
      r_halt       <= 1'b0;
      r_halt_pc    <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_state <= S_FULL;
            r_pc    <= in_pc;
            r_dnpc  <= in_dnpc;
            r_rd    <= in_rd;
            r_wen   <= w_cap_wen;
            r_data  <= w_cap_data;
            r_err   <= in_resp_err;
          end else begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (r_err) begin
            // Faulting instruction never retires; freeze with its PC.
            r_state   <= S_HALT;
            r_halt    <= 1'b1;
            r_halt_pc <= r_pc;
            r_wen     <= 1'b0;
          end else if (w_commit_fire) begin
            r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_in_fire) begin
              r_state <= S_FULL;
              r_pc    <= in_pc;
              r_dnpc  <= in_dnpc;
              r_rd    <= in_rd;
              r_wen   <= w_cap_wen;
              r_data  <= w_cap_data;
              r_err   <= in_resp_err;
            end else begin
              r_state <= S_EMPTY;
              r_wen   <= 1'b0;
            end
          end else begin
            r_state <= S_FULL;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // Output mapping from the held entry; PCs read as zero when nothing is held.
  always_comb begin
    in_ready     = w_in_ready;
    commit_valid = w_commit_valid;
    commit_pc    = w_full ? r_pc   : '0;
    commit_dnpc  = w_full ? r_dnpc : '0;
    rf_wen       = w_commit_fire & r_wen;
    rf_waddr     = r_rd;
    rf_wdata     = r_data;
    busy_valid   = w_full & r_wen;
    busy_rd      = (w_full & r_wen) ? r_rd : 5'd0;
    retire_cnt   = r_retire_cnt;
    halt         = r_halt;
    halt_pc      = r_halt_pc;
  end

endmodule

// File: doc/ysyx_25040109_wbu.md
Name: ysyx_25040109_wbu

Overview:
Write-back/commit stage sitting directly downstream of the LSU/EXU result path. It accepts one completed instruction per handshake, holds it in a single-entry register, and commits it when the IFU accepts the next-PC redirect: a register-file write plus a retire count. Bus error responses are turned into a sticky halt, and the stage exposes its in-flight destination for hazard interlock.

Parameters:
CNT_W, 64, width of the retired-instruction counter
XLEN, 32, datapath width

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  upstream result valid
in_ready  out  1  stage can accept a result this cycle
in_pc  in  XLEN  PC of the instruction
in_dnpc  in  XLEN  next PC computed upstream
in_rd  in  5  destination register index
in_rd_wen  in  1  instruction writes rd
in_is_load  in  1  select in_load_data rather than in_alu_result
in_alu_result  in  XLEN  EXU result
in_load_data  in  XLEN  LSU extended load data
in_resp_err  in  1  LSU bus response error for this instruction
commit_valid  out  1  committed instruction presented to IFU
commit_ready  in  1  IFU accepts the commit/next PC
commit_dnpc  out  XLEN  next PC for IFU
commit_pc  out  XLEN  PC being retired
rf_wen  out  1  register-file write strobe
rf_waddr  out  5  register-file write index
rf_wdata  out  XLEN  register-file write data
busy_rd  out  5  rd of the held entry (hazard check)
busy_valid  out  1  held entry will write busy_rd (rd≠0)
retire_cnt  out  CNT_W  number of committed instructions
halt  out  1  sticky error halt
halt_pc  out  XLEN  PC of the faulting instruction

Behaviour:
- States: EMPTY, FULL, HALT. Reset (reset=0, asynchronous) forces EMPTY. All registered outputs clear to 0: retire_cnt, halt, halt_pc, and the held pc/dnpc/rd/data/flags.
- in_ready = (EMPTY) or (FULL and commit_fire and not err_held). It is 0 in HALT.
- in_fire = in_valid & in_ready. Capture pc, dnpc, rd, wen = in_rd_wen & (in_rd≠0), data = in_is_load ? in_load_data : in_alu_result, err = in_resp_err.
- EMPTY: in_fire → FULL.
- FULL with err_held=0:
  - commit_valid=1; commit_fire = commit_valid & commit_ready.
  - On commit_fire: retire_cnt += 1 (wraps modulo 2^CNT_W).
  - On commit_fire, if in_fire in the same cycle: stay FULL and reload (back-to-back, one commit per cycle). Otherwise → EMPTY.
  - Without commit_fire: hold all fields stable, commit_valid stays 1.
- FULL with err_held=1:
  - commit_valid=0, no register-file write, retire_cnt not incremented.
  - Next edge → HALT, with halt=1 and halt_pc=held pc.
- HALT: absorbing until reset. in_ready=0, commit_valid=0, rf_wen=0.
- rf_wen = commit_fire & wen_held (combinational, same cycle as the commit). rf_waddr/rf_wdata come from the held entry. rd=0 never produces rf_wen.
- busy_valid = (FULL) & wen_held; busy_rd = held rd, or 0 when not busy_valid.
- commit_pc/commit_dnpc show the held values in FULL and 0 otherwise.
- Latency: result accepted at edge N; commit and register-file write are visible in cycle N+1 at the earliest.
- commit_valid must not drop once asserted until commit_fire (AXI-style valid stability). in_valid deasserting while in_ready=0 is tolerated.
- Reset mid-hold: the entry is discarded and no write occurs.

Test Plan:
- Reset, then in_valid=1, pc=0x80000000, dnpc=0x80000004, rd=5, wen=1, alu=0x1234, commit_ready=1 → next cycle rf_wen=1, waddr=5, wdata=0x1234, commit_dnpc=0x80000004, retire_cnt=1.
- Load with is_load=1, load_data=0xFFFFFF80, alu=0xDEAD, and commit_ready=0 for 3 cycles → commit_valid held for 3 cycles, in_ready=0, busy_rd=rd; on ready: one write of 0xFFFFFF80, retire_cnt+1 exactly once.
- Stream 4 back-to-back results with commit_ready=1 → in_ready stays 1, one commit per cycle, retire_cnt goes 0→4.
- rd=0 with wen=1 → commit occurs, rf_wen=0, busy_valid=0.
- in_resp_err=1 at pc=0x80000010 → no commit, next cycle halt=1, halt_pc=0x80000010; later in_valid ignored (in_ready=0); reset=0 clears halt.
- Assert reset=0 mid-cycle while FULL → outputs clear immediately, with no rf_wen.
